// File: rtl/zxw_cam_pkg.sv
// rtl/zxw_cam_pkg.sv - shared widths, opcode and state encodings for the CAM controller
package zxw_cam_pkg;

   localparam int DW    = 6;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   typedef enum logic [1:0] {
      OP_WRITE  = 2'b00,
      OP_READ   = 2'b01,
      OP_SEARCH = 2'b10,
      OP_INVAL  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      WR,
      RD,
      SRCH
   } state_e;

endpackage

// File: rtl/zxw_prio_enc16.sv
// rtl/zxw_prio_enc16.sv - lowest-index priority encoder with any-hit flag
// ZXW_CAM_MHIT_EN adds a population count of the input bits.
module zxw_prio_enc16
   import zxw_cam_pkg::*;
(
   input  logic [DEPTH-1:0] bits,
   output logic             any_hit,
   output logic [AW-1:0]    idx
`ifdef ZXW_CAM_MHIT_EN
   ,
   output logic [AW:0]      cnt
`endif
);

   assign any_hit = |bits;

   // Scanning downward lets the lowest set index win.
   always_comb begin
      idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (bits[i]) idx = AW'(i);
      end
   end

`ifdef ZXW_CAM_MHIT_EN
   always_comb begin
      cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt = cnt + {{AW{1'b0}}, bits[i]};
      end
   end
`endif

endmodule

// File: rtl/zxw_cam_ctrl.sv
// rtl/zxw_cam_ctrl.sv - request/response sequencer for a 16x6 CAM with per-entry valid bits
// ZXW_CAM_MHIT_EN adds the resp_multi/resp_cnt multi-hit outputs.
module zxw_cam_ctrl
   import zxw_cam_pkg::*;
#(
   parameter int SETTLE_CYC = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [AW-1:0]    req_addr,
   input  logic [DW-1:0]    req_data,
   output logic             resp_valid,
   output logic [DW-1:0]    resp_data,
   output logic             resp_hit,
   output logic [AW-1:0]    resp_idx,
`ifdef ZXW_CAM_MHIT_EN
   output logic             resp_multi,
   output logic [AW:0]      resp_cnt,
`endif
   output logic             cam_we_n,
   output logic             cam_rd_n,
   output logic [DW-1:0]    cam_din,
   output logic [DW-1:0]    cam_argin,
   output logic [AW-1:0]    cam_addrs,
   input  logic [DW-1:0]    cam_dout,
   input  logic [DEPTH-1:0] cam_mbits
);

   localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYC - 1);

   state_e           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic             cam_we_n_q, cam_we_n_d;
   logic             cam_rd_n_q, cam_rd_n_d;
   logic [DW-1:0]    cam_din_q, cam_din_d;
   logic [DW-1:0]    cam_argin_q, cam_argin_d;
   logic [AW-1:0]    cam_addrs_q, cam_addrs_d;
   logic             resp_valid_q, resp_valid_d;
   logic [DW-1:0]    resp_data_q, resp_data_d;
   logic             resp_hit_q, resp_hit_d;
   logic [AW-1:0]    resp_idx_q, resp_idx_d;
   logic             enc_any;
   logic [AW-1:0]    enc_idx;
   op_e              op;

   assign op = op_e'(req_op);

   // Raw CAM matches on invalidated entries are stale and must not count.
`ifdef ZXW_CAM_MHIT_EN
   logic             resp_multi_q, resp_multi_d;
   logic [AW:0]      resp_cnt_q, resp_cnt_d;
   logic [AW:0]      enc_cnt;

   zxw_prio_enc16 u_enc (
      .bits    (cam_mbits & valid_q),
      .any_hit (enc_any),
      .idx     (enc_idx),
      .cnt     (enc_cnt)
   );
`else
   zxw_prio_enc16 u_enc (
      .bits    (cam_mbits & valid_q),
      .any_hit (enc_any),
      .idx     (enc_idx)
   );
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      valid_d      = valid_q;
      cam_we_n_d   = cam_we_n_q;
      cam_rd_n_d   = cam_rd_n_q;
      cam_din_d    = cam_din_q;
      cam_argin_d  = cam_argin_q;
      cam_addrs_d  = cam_addrs_q;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
      resp_hit_d   = resp_hit_q;
      resp_idx_d   = resp_idx_q;
`ifdef ZXW_CAM_MHIT_EN
      resp_multi_d = resp_multi_q;
      resp_cnt_d   = resp_cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               unique case (op)
                  OP_WRITE: begin
                     cam_addrs_d = req_addr;
                     cam_din_d   = req_data;
                     cam_we_n_d  = 1'b0;
                     state_d     = WR;
                  end
                  OP_READ: begin
                     cam_addrs_d = req_addr;
                     cam_rd_n_d  = 1'b0;
                     cnt_d       = SETTLE_LAST;
                     state_d     = RD;
                  end
                  OP_SEARCH: begin
                     cam_argin_d = req_data;
                     cnt_d       = SETTLE_LAST;
                     state_d     = SRCH;
                  end
                  OP_INVAL: begin
                     valid_d[req_addr] = 1'b0;
                     resp_valid_d      = 1'b1;
`ifdef ZXW_CAM_MHIT_EN
                     resp_multi_d      = 1'b0;
                     resp_cnt_d        = '0;
`endif
                  end
               endcase
            end
         end
         WR: begin
            valid_d[cam_addrs_q] = 1'b1;
            cam_we_n_d           = 1'b1;
            resp_valid_d         = 1'b1;
            state_d              = IDLE;
`ifdef ZXW_CAM_MHIT_EN
            resp_multi_d         = 1'b0;
            resp_cnt_d           = '0;
`endif
         end
         RD: begin
            if (cnt_q == 3'd0) begin
               cam_rd_n_d   = 1'b1;
               resp_valid_d = 1'b1;
               resp_data_d  = cam_dout;
               resp_hit_d   = valid_q[cam_addrs_q];
               state_d      = IDLE;
`ifdef ZXW_CAM_MHIT_EN
               resp_multi_d = 1'b0;
               resp_cnt_d   = '0;
`endif
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         SRCH: begin
            if (cnt_q == 3'd0) begin
               resp_valid_d = 1'b1;
               resp_hit_d   = enc_any;
               resp_idx_d   = enc_idx;
               state_d      = IDLE;
`ifdef ZXW_CAM_MHIT_EN
               resp_multi_d = (enc_cnt > 5'd1);
               resp_cnt_d   = enc_cnt;
`endif
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         valid_q      <= '0;
         cam_we_n_q   <= 1'b1;
         cam_rd_n_q   <= 1'b1;
         cam_din_q    <= '0;
         cam_argin_q  <= '0;
         cam_addrs_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_hit_q   <= 1'b0;
         resp_idx_q   <= '0;
`ifdef ZXW_CAM_MHIT_EN
         resp_multi_q <= 1'b0;
         resp_cnt_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         valid_q      <= valid_d;
         cam_we_n_q   <= cam_we_n_d;
         cam_rd_n_q   <= cam_rd_n_d;
         cam_din_q    <= cam_din_d;
         cam_argin_q  <= cam_argin_d;
         cam_addrs_q  <= cam_addrs_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_hit_q   <= resp_hit_d;
         resp_idx_q   <= resp_idx_d;
`ifdef ZXW_CAM_MHIT_EN
         resp_multi_q <= resp_multi_d;
         resp_cnt_q   <= resp_cnt_d;
`endif
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_hit   = resp_hit_q;
   assign resp_idx   = resp_idx_q;
`ifdef ZXW_CAM_MHIT_EN
   assign resp_multi = resp_multi_q;
   assign resp_cnt   = resp_cnt_q;
`endif
   assign cam_we_n   = cam_we_n_q;
   assign cam_rd_n   = cam_rd_n_q;
   assign cam_din    = cam_din_q;
   assign cam_argin  = cam_argin_q;
   assign cam_addrs  = cam_addrs_q;

endmodule

// File: tb/tb_zxw_cam_ctrl.sv
// tb/tb_zxw_cam_ctrl.sv - randomized self-checking bench for zxw_cam_ctrl with a CAM array model
module tb_zxw_cam_ctrl;

   localparam int S = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [3:0]  req_addr = 4'd0;
   logic [5:0]  req_data = 6'd0;
   logic        resp_valid;
   logic [5:0]  resp_data;
   logic        resp_hit;
   logic [3:0]  resp_idx;
   logic        resp_multi;
   logic [4:0]  resp_cnt;
   logic        cam_we_n, cam_rd_n;
   logic [5:0]  cam_din, cam_argin, cam_dout;
   logic [3:0]  cam_addrs;
   logic [15:0] cam_mbits;

   always #5 clk = ~clk;

   zxw_cam_ctrl #(.SETTLE_CYC(S)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_hit   (resp_hit),
      .resp_idx   (resp_idx),
`ifdef ZXW_CAM_MHIT_EN
      .resp_multi (resp_multi),
      .resp_cnt   (resp_cnt),
`endif
      .cam_we_n   (cam_we_n),
      .cam_rd_n   (cam_rd_n),
      .cam_din    (cam_din),
      .cam_argin  (cam_argin),
      .cam_addrs  (cam_addrs),
      .cam_dout   (cam_dout),
      .cam_mbits  (cam_mbits)
   );

`ifndef ZXW_CAM_MHIT_EN
   assign resp_multi = 1'b0;
   assign resp_cnt   = 5'd0;
`endif

   // CAM array driven only by the controller's strobes
   logic [5:0] cam_mem [16];
   logic       force_all = 1'b0;

   always @(posedge clk) if (!cam_we_n) cam_mem[cam_addrs] <= cam_din;
   assign cam_dout = cam_mem[cam_addrs];
   always_comb begin
      cam_mbits = '0;
      for (int i = 0; i < 16; i++) cam_mbits[i] = force_all || (cam_mem[i] == cam_argin);
   end

   // Reference model
   typedef struct {
      int         due;
      logic [5:0] data;
      logic       hit;
      logic [3:0] idx;
      logic       multi;
      logic [4:0] cnt;
   } exp_t;

   exp_t        q[$];
   exp_t        cur, last;
   logic [5:0]  m_mem [16];
   logic [15:0] m_valid = '0;
   int          cyc = 0;
   int          acc_t = -100;
   int          acc_l = 0;
   logic [1:0]  acc_op = 2'b00;
   int          n_cmp = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   task automatic model_accept(input logic [1:0] op, input logic [3:0] addr, input logic [5:0] data, input int t);
      exp_t e;
      int   n;
      e = last;
      e.multi = 1'b0;
      e.cnt   = 5'd0;
      case (op)
         2'b00: begin
            e.due = t + 2;
            m_mem[addr]   = data;
            m_valid[addr] = 1'b1;
         end
         2'b01: begin
            e.due  = t + 1 + S;
            e.data = m_mem[addr];
            e.hit  = m_valid[addr];
         end
         2'b10: begin
            e.due = t + 1 + S;
            n = 0;
            e.idx = 4'd0;
            for (int i = 15; i >= 0; i--) begin
               if (m_valid[i] && (force_all || m_mem[i] == data)) begin
                  n++;
                  e.idx = 4'(i);
               end
            end
            e.hit   = (n > 0);
            e.multi = (n > 1);
            e.cnt   = 5'(n);
         end
         default: begin
            e.due = t + 1;
            m_valid[addr] = 1'b0;
         end
      endcase
      last = e;
      q.push_back(e);
      acc_t  = t;
      acc_op = op;
      acc_l  = e.due - t;
   endtask

   task automatic model_reset();
      q.delete();
      m_valid = '0;
      cur  = '{default: 0};
      last = '{default: 0};
      acc_t = -100;
      acc_l = 0;
   endtask

   // Per-cycle compare against the model
   initial begin
      logic exp_v;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            exp_v = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
               cur = q.pop_front();
               exp_v = 1'b1;
            end
            chk("resp_valid", resp_valid, exp_v);
            chk("resp_data", resp_data, cur.data);
            chk("resp_hit", resp_hit, cur.hit);
            chk("resp_idx", resp_idx, cur.idx);
`ifdef ZXW_CAM_MHIT_EN
            chk("resp_multi", resp_multi, cur.multi);
            chk("resp_cnt", resp_cnt, cur.cnt);
`endif
            chk("req_ready", req_ready, !(cyc >= acc_t + 1 && cyc <= acc_t + acc_l - 1));
            chk("cam_we_n", cam_we_n, !(acc_op == 2'b00 && cyc == acc_t + 1));
            chk("cam_rd_n", cam_rd_n, !(acc_op == 2'b01 && cyc >= acc_t + 1 && cyc <= acc_t + S));
            chk("strobe_overlap", cam_we_n | cam_rd_n, 1);
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [3:0] addr, input logic [5:0] data);
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_data  = data;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("accept_timeout", req_ready, 1);
         req_valid = 1'b0;
         return;
      end
      model_accept(op, addr, data, cyc);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp();
      int n;
      n = 0;
      while (!resp_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("resp_timeout", resp_valid, 1);
   endtask

   task automatic chk_srch(input logic hit, input logic [3:0] idx, input logic [4:0] cnt, input logic multi);
      chk("dir_hit", resp_hit, hit);
      chk("dir_idx", resp_idx, idx);
`ifdef ZXW_CAM_MHIT_EN
      chk("dir_cnt", resp_cnt, cnt);
      chk("dir_multi", resp_multi, multi);
`else
      if (cnt != 5'd0 && multi) chk("dir_cnt_port_tied", resp_cnt, 0);
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] pool [4];
      logic [5:0] old;
      pool[0] = 6'h00; pool[1] = 6'h15; pool[2] = 6'h2A; pool[3] = 6'h3F;
      for (int i = 0; i < 16; i++) begin
         cam_mem[i] = 6'd0;
         m_mem[i]   = 6'd0;
      end
      model_reset();

      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_we_n", cam_we_n, 1);
      chk("rst_rd_n", cam_rd_n, 1);
      chk("rst_din", cam_din, 0);
      chk("rst_argin", cam_argin, 0);
      chk("rst_addrs", cam_addrs, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_hit", resp_hit, 0);
      chk("rst_resp_idx", resp_idx, 0);
      rst_n = 1'b1;

      // Search right after reset with every raw match bit set
      force_all = 1'b1;
      issue(2'b10, 4'd0, 6'h00);
      wait_resp();
      chk_srch(1'b0, 4'd0, 5'd0, 1'b0);
      force_all = 1'b0;

      for (int a = 0; a < 16; a++) issue(2'b00, 4'(a), 6'h15);
      issue(2'b10, 4'd0, 6'h15);
      wait_resp();
      chk_srch(1'b1, 4'd0, 5'd16, 1'b1);

      for (int a = 0; a < 16; a++) begin
         issue(2'b01, 4'(a), 6'h00);
         wait_resp();
         chk("dir_rd_data", resp_data, 6'h15);
         chk("dir_rd_hit", resp_hit, 1);
      end

      issue(2'b00, 4'd5, 6'h3F);
      issue(2'b10, 4'd0, 6'h3F);
      wait_resp();
      chk_srch(1'b1, 4'd5, 5'd1, 1'b0);
      issue(2'b10, 4'd0, 6'h15);
      wait_resp();
      chk_srch(1'b1, 4'd0, 5'd15, 1'b1);

      issue(2'b11, 4'd5, 6'h00);
      chk("inv_resp_next_cycle", resp_valid, 1);
      issue(2'b10, 4'd0, 6'h3F);
      wait_resp();
      chk_srch(1'b0, 4'd0, 5'd0, 1'b0);

      // Reset while the write strobe is low
      old = m_mem[3];
      issue(2'b00, 4'd3, 6'h2A);
      chk("we_low_before_rst", cam_we_n, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("we_n_in_rst", cam_we_n, 1);
      chk("resp_valid_in_rst", resp_valid, 0);
      model_reset();
      m_mem[3] = old;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", req_ready, 1);

      repeat (400) begin
         issue(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), pool[$urandom_range(0, 3)]);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (S + 4) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
